bcd_number_validator: RTL

BCD_NUMBER_VALIDATOR -- requirements
Module: bcd_number_validator

---
 rtl/bcd_number_validator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bcd_number_validator.sv
// -----------------------------------------------------------------------------
// bcd_number_validator
//
// Collects a stream of radix-(MAX_DIGIT+1) digits, most significant first, and
// converts them to a binary value. A number ends on a digit flagged with
// in_last or when NUM_DIGITS digits have been taken. Every digit is range
// checked and the running value is checked for overflow of OUT_W bits. Any
// error is sticky for the rest of the number. The result is then held on a
// valid/ready output until the consumer takes it.
//
// Optional feature (compile-time macro BCD_VALIDATOR_XCHECK_EN):
//   When the macro is defined, an accepted in_digit or in_last holding X/Z
//   bits flags an error, and such a digit counts as 0 in the accumulator.
//   When it is undefined, only the range and overflow checks are built.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   in_valid     in   in_digit / in_last are presented
//   in_digit     in   [3:0] digit, MSD first
//   in_last      in   current digit terminates the number
//   in_ready     out  block accepts a digit (registered)
//   out_valid    out  result presented (registered)
//   out_ready    in   downstream consumes the result
//   out_value    out  [OUT_W-1:0] binary value, 0 when out_err=1
//   out_err      out  number contained an error
//   out_ndigits  out  [$clog2(NUM_DIGITS+1)-1:0] digits accepted
// -----------------------------------------------------------------------------
module bcd_number_validator #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_DIGIT  = 9,
    parameter int OUT_W      = 14
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [3:0]                            in_digit,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_W-1:0]                      out_value,
    output logic                                  out_err,
    output logic [$clog2(NUM_DIGITS+1)-1:0]       out_ndigits
);

    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int RADIX  = MAX_DIGIT + 1;
    // Radix is at most 16, so multiply-add needs 4 extra bits plus one carry.
    localparam int FULL_W = OUT_W + 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q;
    logic [OUT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_value_q;
    logic               out_err_q;
    logic [CNT_W-1:0]   out_ndigits_q;

    logic [3:0]         digit_eff;
    logic               last_eff;
    logic               bad_x;
    logic [OUT_W-1:0]   acc_base;
    logic [CNT_W-1:0]   cnt_base;
    logic               err_base;
    logic [FULL_W-1:0]  full;
    logic               range_err;
    logic               ovf_err;
    logic [OUT_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               err_d;
    logic               term;
    logic               accept;

    // Next-state datapath for an accepted digit. In IDLE the number restarts,
    // so the running acc/cnt/err are treated as zero: acc*R+d then reduces
    // to a plain load of the digit and the overflow check still applies.
    always_comb begin
        digit_eff = in_digit;
        last_eff  = in_last;
        bad_x     = 1'b0;
`ifdef BCD_VALIDATOR_XCHECK_EN
        if ((^in_digit) === 1'bx) begin
            digit_eff = 4'd0;
            bad_x     = 1'b1;
        end
        // An unknown in_last cannot be trusted to end the number; the digit
        // counter still terminates it at NUM_DIGITS.
        if ((in_last !== 1'b0) && (in_last !== 1'b1)) begin
            last_eff = 1'b0;
            bad_x    = 1'b1;
        end
`endif
        acc_base  = (state_q == COLLECT) ? acc_q : '0;
        cnt_base  = (state_q == COLLECT) ? cnt_q : '0;
        err_base  = (state_q == COLLECT) ? err_q : 1'b0;

        full      = FULL_W'(acc_base) * FULL_W'(RADIX) + FULL_W'(digit_eff);
        ovf_err   = |full[FULL_W-1:OUT_W];
        range_err = (int'(digit_eff) > MAX_DIGIT);

        acc_d     = full[OUT_W-1:0];
        cnt_d     = cnt_base + CNT_W'(1);
        err_d     = err_base | range_err | ovf_err | bad_x;
        term      = last_eff | (cnt_d == CNT_W'(NUM_DIGITS));
        accept    = in_valid & in_ready_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_value_q   <= '0;
            out_err_q     <= 1'b0;
            out_ndigits_q <= '0;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        err_q <= err_d;
                        if (term) begin
                            state_q       <= DONE;
                            in_ready_q    <= 1'b0;
                            out_valid_q   <= 1'b1;
                            out_value_q   <= err_d ? '0 : acc_d;
                            out_err_q     <= err_d;
                            out_ndigits_q <= cnt_d;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    // Result registers are left untouched here, so they stay
                    // stable for as long as the consumer stalls.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_value   = out_value_q;
    assign out_err     = out_err_q;
    assign out_ndigits = out_ndigits_q;

endmodule
